// File: rtl/hex_disp_pkg.sv
// Shared constants and helpers for the two-digit hex counter / display path.
//   DIGIT_W       : width of one hex digit
//   COUNT_W       : width of the full two-digit count
//   PRESCALE_HW   : ticks for 1 s at 50 MHz; PRESCALE_SIM for fast simulation
//   count_step    : +/-1 modulo 2^COUNT_W
//   count_wraps   : true when that step crosses 0xFF <-> 0x00
package hex_disp_pkg;
  localparam int DIGIT_W      = 4;
  localparam int COUNT_W      = 2 * DIGIT_W;
  localparam int PRESCALE_HW  = 50000000;
  localparam int PS_W_HW      = 26;
  localparam int PRESCALE_SIM = 4;
  localparam int PS_W_SIM     = 3;

  function automatic logic [COUNT_W-1:0] count_step(input logic [COUNT_W-1:0] v,
                                                    input logic             up);
    return up ? v + COUNT_W'(1) : v - COUNT_W'(1);
  endfunction

  function automatic logic count_wraps(input logic [COUNT_W-1:0] v, input logic up);
    return up ? (v == '1) : (v == '0);
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock down to one count tick every PRESCALE enabled cycles.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : advance the prescaler this cycle (holds value when low)
//   i_clr          : restart the period from zero (wins over i_en)
//   o_tick         : combinational, high in the cycle the period completes
module tick_prescaler #(
  parameter int PRESCALE = 50000000,
  parameter int PS_W     = 26
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  logic [PS_W-1:0] r_ps;
  logic            w_last;

  assign w_last = (r_ps == PS_W'(PRESCALE - 1));
  assign o_tick = i_en && !i_clr && w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_ps <= '0;
    else if (i_clr) r_ps <= '0;
    else if (i_en)  r_ps <= w_last ? '0 : r_ps + PS_W'(1);
  end
endmodule

// File: rtl/hex_pair_counter.sv
// Prescaled 8-bit up/down counter feeding a two-digit hex display.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_run          : 1 = count, 0 = hold (async level)
//   i_up           : 1 = increment, 0 = decrement (async level)
//   i_clear        : forces count to 0x00 while high (async level)
//   i_load         : rising edge loads i_load_val (async button)
//   i_load_val     : load value; [3:0] -> o_a, [7:4] -> o_b
//   o_a, o_b       : low / high hex digit
//   o_tick         : one-cycle pulse when a tick updates the count
//   o_wrap         : one-cycle pulse on 0xFF->0x00 or 0x00->0xFF
// Every control input goes through SYNC_STAGES flops; pin-to-effect latency
// is SYNC_STAGES+1 cycles. Priority: clear > load edge > tick.
module hex_pair_counter
  import hex_disp_pkg::*;
#(
  parameter int PRESCALE    = PRESCALE_HW,
  parameter int PS_W        = PS_W_HW,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run,
  input  logic               i_up,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [COUNT_W-1:0] i_load_val,
  output logic [DIGIT_W-1:0] o_a,
  output logic [DIGIT_W-1:0] o_b,
  output logic               o_tick,
  output logic               o_wrap
);
  logic [SYNC_STAGES-1:0]              r_run_sync, r_up_sync, r_clr_sync, r_ld_sync;
  logic [SYNC_STAGES-1:0][COUNT_W-1:0] r_lv_sync;
  logic [SYNC_STAGES-1:0]              r_fill;
  logic                                r_ld_d, r_ld_armed;
  logic [COUNT_W-1:0]                  r_val;
  logic                                r_tick, r_wrap;

  logic               w_run_s, w_up_s, w_clr_s, w_ld_s, w_sync_valid;
  logic [COUNT_W-1:0] w_lv_s;
  logic               w_ld_edge, w_tick;

  assign w_run_s      = r_run_sync[SYNC_STAGES-1];
  assign w_up_s       = r_up_sync[SYNC_STAGES-1];
  assign w_clr_s      = r_clr_sync[SYNC_STAGES-1];
  assign w_ld_s       = r_ld_sync[SYNC_STAGES-1];
  assign w_lv_s       = r_lv_sync[SYNC_STAGES-1];
  // High once the sync chains hold real pin samples rather than reset zeros.
  assign w_sync_valid = r_fill[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run_sync <= '0;
      r_up_sync  <= '0;
      r_clr_sync <= '0;
      r_ld_sync  <= '0;
      r_lv_sync  <= '0;
      r_fill     <= '0;
    end else begin
      r_run_sync <= {r_run_sync[SYNC_STAGES-2:0], i_run};
      r_up_sync  <= {r_up_sync[SYNC_STAGES-2:0], i_up};
      r_clr_sync <= {r_clr_sync[SYNC_STAGES-2:0], i_clear};
      r_ld_sync  <= {r_ld_sync[SYNC_STAGES-2:0], i_load};
      r_fill     <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_lv_sync[0] <= i_load_val;
      for (int s = 1; s < SYNC_STAGES; s++) r_lv_sync[s] <= r_lv_sync[s-1];
    end
  end

  // The reset-cleared sync chain would make a button held through reset look
  // like a fresh press. Loads are only armed after a genuine low sample of
  // the pin has been seen since reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ld_d     <= 1'b0;
      r_ld_armed <= 1'b0;
    end else begin
      r_ld_d <= w_ld_s;
      if (w_sync_valid && !w_ld_s) r_ld_armed <= 1'b1;
    end
  end

  assign w_ld_edge = w_ld_s && !r_ld_d && r_ld_armed;

  tick_prescaler #(.PRESCALE(PRESCALE), .PS_W(PS_W)) u_ps (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (w_run_s && !w_clr_s && !w_ld_edge),
    .i_clr  (w_clr_s || w_ld_edge),
    .o_tick (w_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_val  <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (w_clr_s)        r_val <= '0;
      else if (w_ld_edge) r_val <= w_lv_s;
      else if (w_tick) begin
        r_val  <= count_step(r_val, w_up_s);
        r_tick <= 1'b1;
        r_wrap <= count_wraps(r_val, w_up_s);
      end
    end
  end

  assign o_a    = r_val[DIGIT_W-1:0];
  assign o_b    = r_val[COUNT_W-1:DIGIT_W];
  assign o_tick = r_tick;
  assign o_wrap = r_wrap;
endmodule
